wb_protocol_monitor: RTL and testbench

Synthesizable, parametrised Wishbone B3 protocol monitor that passively observes one master/slave pair on the whitebox interface. It extends the reset-rule assertions (rules 3.00/3.05) into hardware checks covering handshake, signal stability, timeout and registered-feedback burst rules. It reports violations as sticky flags, a per-violation pulse with an error code, and saturating transaction, burst and error counters. The block drives nothing on the bus and is instantiated beside the DUT in both simulation and FPGA builds.

---
 rtl/wb_protocol_monitor.sv | 186 ++++++++++++++++++
 tb/tb_wb_protocol_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone B3 protocol monitor; `WB_MON_BURST_EN adds cti/burst tracking, codes 5/6 and burst_count_o.
// Results register on the edge that samples the offending bus cycle; drives nothing, exerts no backpressure.
module wb_protocol_monitor #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic [2:0]          wb_cti_i,
  input  logic                wb_ack_o,
  input  logic                clr_i,
  output logic                err_valid_o,
  output logic [2:0]          err_code_o,
  output logic [7:0]          err_flags_o,
  output logic [CNT_W-1:0]    txn_count_o,
  output logic [CNT_W-1:0]    burst_count_o,
  output logic [CNT_W-1:0]    err_count_o
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [1:0]          r_state;
  logic                r_pend;
  logic                r_post_rst;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W/8-1:0] r_sel;
  logic [DATA_W-1:0]   r_dat;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_err_valid;
  logic [2:0]          r_err_code;
  logic [7:0]          r_err_flags;
  logic [CNT_W-1:0]    r_txn_cnt;
  logic [CNT_W-1:0]    r_err_cnt;

  logic       w_strb;
  logic       w_acked;
  logic       w_wait;
  logic       w_first;
  logic       w_changed;
  logic       w_burst_start;
  logic       w_burst_done;
  logic       w_viol_addr;
  logic       w_viol_abort;
  logic [7:0] w_viol;
  logic [2:0] w_code;
  logic [1:0] w_state_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc,
                                               input logic clr);
    if (clr) return CNT_W'(inc);
    if (inc && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  assign w_strb    = wb_cyc_i & wb_stb_i;
  assign w_acked   = w_strb & wb_ack_o;
  assign w_wait    = w_strb & ~wb_ack_o;
  assign w_first   = w_strb & ~r_pend;
  assign w_changed = (wb_addr_i != r_addr) | (wb_we_i != r_we) | (wb_sel_i != r_sel) |
                     (wb_we_i & (wb_dat_i != r_dat));

`ifdef WB_MON_BURST_EN
  localparam logic [2:0]        CTI_INC    = 3'b010;
  localparam logic [2:0]        CTI_END    = 3'b111;
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

  logic             w_in_burst;
  logic             w_cti_bad;
  logic [CNT_W-1:0] r_burst_cnt;

  assign w_in_burst    = (r_state == S_BURST);
  assign w_cti_bad     = w_strb & (wb_cti_i != CTI_INC) & (wb_cti_i != CTI_END);
  assign w_burst_start = w_acked & (wb_cti_i == CTI_INC);
  assign w_burst_done  = w_in_burst & w_acked & (wb_cti_i == CTI_END);
  // r_addr still holds the previous beat's address on the first strobe of the next beat
  assign w_viol_addr   = w_in_burst & w_first & (wb_addr_i != r_addr + BEAT_BYTES);
  assign w_viol_abort  = w_in_burst & (~wb_cyc_i | w_cti_bad);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_burst_cnt <= '0;
    else          r_burst_cnt <= sat_inc(r_burst_cnt, w_burst_done, clr_i);
  end
  assign burst_count_o = r_burst_cnt;
`else
  logic w_unused_cti;
  assign w_unused_cti  = ^wb_cti_i;
  assign w_burst_start = 1'b0;
  assign w_burst_done  = 1'b0;
  assign w_viol_addr   = 1'b0;
  assign w_viol_abort  = 1'b0;
  assign burst_count_o = '0;
`endif

  assign w_viol[0] = wb_ack_o & ~w_strb;
  assign w_viol[1] = wb_stb_i & ~wb_cyc_i;
  assign w_viol[2] = r_pend & ~w_strb;
  assign w_viol[3] = r_pend & w_strb & w_changed;
  assign w_viol[4] = r_pend & w_wait & (r_tmo == TMO_LAST);
  assign w_viol[5] = w_viol_addr;
  assign w_viol[6] = w_viol_abort;
  assign w_viol[7] = r_post_rst & (wb_cyc_i | wb_stb_i);

  always_comb begin
    w_code = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_viol[i]) w_code = 3'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_burst_start)   w_state_nxt = S_BURST;
        else if (w_wait)     w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!w_strb)            w_state_nxt = S_IDLE;
        else if (w_burst_start) w_state_nxt = S_BURST;
        else if (w_acked)       w_state_nxt = S_IDLE;
      end
      S_BURST: begin
        if (w_viol_abort || w_burst_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_pend      <= 1'b0;
      r_post_rst  <= 1'b1;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_dat       <= '0;
      r_tmo       <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= 3'd0;
      r_err_flags <= 8'h00;
      r_txn_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_wait;
      r_post_rst <= 1'b0;
      if (w_first) begin
        r_addr <= wb_addr_i;
        r_we   <= wb_we_i;
        r_sel  <= wb_sel_i;
        r_dat  <= wb_dat_i;
      end
      // Counts waiting cycles of the current access; holding at TIMEOUT keeps the flag one-shot
      if (!w_wait)              r_tmo <= '0;
      else if (!r_pend)         r_tmo <= TMO_W'(1);
      else if (r_tmo != TMO_MAX) r_tmo <= r_tmo + 1'b1;
      r_err_valid <= |w_viol;
      if (|w_viol) r_err_code <= w_code;
      r_err_flags <= (clr_i ? 8'h00 : r_err_flags) | w_viol;
      r_txn_cnt   <= sat_inc(r_txn_cnt, w_acked, clr_i);
      r_err_cnt   <= sat_inc(r_err_cnt, |w_viol, clr_i);
    end
  end

  assign err_valid_o = r_err_valid;
  assign err_code_o  = r_err_code;
  assign err_flags_o = r_err_flags;
  assign txn_count_o = r_txn_cnt;
  assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Bench for wb_protocol_monitor: directed protocol scenarios then random bus traffic
// checked every cycle against a cycle-history reference model.
module tb_wb_protocol_monitor;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int TMO  = 8;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;
`ifdef WB_MON_BURST_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0, ack = 1'b0, clr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] dat  = '0;
  logic [3:0]    sel  = 4'hF;
  logic [2:0]    cti  = 3'd0;

  logic          err_valid;
  logic [2:0]    err_code;
  logic [7:0]    err_flags;
  logic [CW-1:0] txn_cnt, burst_cnt, err_cnt;

  wb_protocol_monitor #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_cti_i(cti), .wb_ack_o(ack),
    .clr_i(clr), .err_valid_o(err_valid), .err_code_o(err_code), .err_flags_o(err_flags),
    .txn_count_o(txn_cnt), .burst_count_o(burst_cnt), .err_count_o(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: expected outputs plus a description of the access in flight
  bit            m_valid;
  logic [2:0]    m_code;
  logic [7:0]    m_flags;
  int            m_txn, m_burst, m_errc;
  int            run_len;      // consecutive strobed-but-unacked cycles of the open access
  bit            in_burst, post_rst;
  logic [AW-1:0] last_addr, s_addr;
  logic          s_we;
  logic [3:0]    s_sel;
  logic [DW-1:0] s_dat;

  logic [2:0] cti_tab [8] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd7, 3'd7, 3'd0, 3'd3};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_code = 3'd0; m_flags = 8'h00;
    m_txn = 0; m_burst = 0; m_errc = 0;
    run_len = 0; in_burst = 0; post_rst = 1;
    last_addr = '0; s_addr = '0; s_we = 1'b0; s_sel = '0; s_dat = '0;
  endtask

  task automatic model_edge();
    logic [7:0]    v;
    logic [AW-1:0] nxt;
    bit strobed, pend, first, acked, bdone;
    v = 8'h00;
    strobed = cyc && stb;
    pend    = (run_len > 0);
    first   = strobed && !pend;
    acked   = strobed && ack;
    bdone   = 0;
    nxt     = last_addr + 16'd4;
    if (ack && !strobed) v[0] = 1'b1;
    if (stb && !cyc) v[1] = 1'b1;
    if (pend && !strobed) v[2] = 1'b1;
    if (pend && strobed && (addr != s_addr || we != s_we || sel != s_sel || (we && dat != s_dat)))
      v[3] = 1'b1;
    if (strobed && !ack && (run_len + 1 == TMO)) v[4] = 1'b1;
    if (BEN && in_burst) begin
      if (first && addr != nxt) v[5] = 1'b1;
      if (!cyc || (strobed && cti != 3'b010 && cti != 3'b111)) v[6] = 1'b1;
    end
    if (post_rst && (cyc || stb)) v[7] = 1'b1;
    if (BEN) begin
      if (in_burst) begin
        if (v[6]) in_burst = 0;
        else if (acked && cti == 3'b111) begin in_burst = 0; bdone = 1; end
      end else if (acked && cti == 3'b010) in_burst = 1;
    end
    if (first) begin
      last_addr = addr; s_addr = addr; s_we = we; s_sel = sel; s_dat = dat;
    end
    run_len  = (strobed && !ack) ? run_len + 1 : 0;
    post_rst = 0;
    m_valid  = (v != 8'h00);
    for (int i = 7; i >= 0; i--) if (v[i]) m_code = 3'(i);
    m_flags = clr ? v : (m_flags | v);
    if (clr) begin
      m_txn = int'(acked); m_burst = int'(bdone); m_errc = int'(m_valid);
    end else begin
      if (acked && m_txn < CMAX) m_txn++;
      if (bdone && m_burst < CMAX) m_burst++;
      if (m_valid && m_errc < CMAX) m_errc++;
    end
  endtask

  task automatic compare_all();
    check_val("err_valid", 32'(err_valid), 32'(m_valid));
    check_val("err_code", 32'(err_code), 32'(m_code));
    check_val("err_flags", 32'(err_flags), 32'(m_flags));
    check_val("txn_count", 32'(txn_cnt), 32'(m_txn));
    check_val("burst_count", 32'(burst_cnt), 32'(m_burst));
    check_val("err_count", 32'(err_cnt), 32'(m_errc));
  endtask

  task automatic drv(input logic c, input logic s, input logic w, input logic [AW-1:0] a,
                     input logic [2:0] t, input logic k);
    cyc = c; stb = s; we = w; addr = a; cti = t; ack = k;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    drv(1'b0, 1'b0, 1'b0, '0, 3'd0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic clear_pulse();
    clr = 1'b1; idle(1); clr = 1'b0;
  endtask

  // Raises reset between edges and checks the asynchronous clear before any edge arrives
  task automatic do_reset(input logic hold_cyc);
    rst = 1'b1;
    model_reset();
    #1;
    check_val("rst_valid", 32'(err_valid), 0);
    check_val("rst_code", 32'(err_code), 0);
    check_val("rst_flags", 32'(err_flags), 0);
    check_val("rst_txn", 32'(txn_cnt), 0);
    check_val("rst_burst", 32'(burst_cnt), 0);
    check_val("rst_errc", 32'(err_cnt), 0);
    drv(hold_cyc, 1'b0, 1'b0, '0, 3'd0, 1'b0);
    clr = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic burst_seq(input logic [AW-1:0] a3, input bit drop);
    drv(1'b1, 1'b1, 1'b1, 16'h0, 3'b010, 1'b1); tick();
    drv(1'b1, 1'b1, 1'b1, 16'h4, 3'b010, 1'b1); tick();
    if (drop) idle(2);
    else begin
      drv(1'b1, 1'b1, 1'b1, a3, 3'b010, 1'b1); tick();
      drv(1'b1, 1'b1, 1'b1, 16'hC, 3'b111, 1'b1); tick();
      idle(1);
    end
  endtask

  initial begin
    logic p_wait, p_inc;
    int   slow;
    #2;
    do_reset(1'b0);
    idle(2);

    // single write acked after three waiting cycles
    dat = 32'hA5A5_0001;
    drv(1'b1, 1'b1, 1'b1, 16'h100, 3'd0, 1'b0); repeat (3) tick();
    drv(1'b1, 1'b1, 1'b1, 16'h100, 3'd0, 1'b1); tick();
    idle(1);
    check_val("single_txn", 32'(txn_cnt), 1);
    check_val("single_flags", 32'(err_flags), 0);

    // ack without strobe
    drv(1'b0, 1'b0, 1'b0, '0, 3'd0, 1'b1); tick();
    check_val("ack_nostb_valid", 32'(err_valid), 1);
    check_val("ack_nostb_code", 32'(err_code), 0);
    check_val("ack_nostb_flags", 32'(err_flags), 32'h01);
    check_val("ack_nostb_errc", 32'(err_cnt), 1);
    idle(1);
    check_val("valid_pulse_end", 32'(err_valid), 0);
    clear_pulse();
    check_val("clr_flags", 32'(err_flags), 0);
    check_val("clr_txn", 32'(txn_cnt), 0);
    check_val("clr_errc", 32'(err_cnt), 0);

    // address change while a read is pending
    drv(1'b1, 1'b1, 1'b0, 16'h100, 3'd0, 1'b0); tick();
    drv(1'b1, 1'b1, 1'b0, 16'h104, 3'd0, 1'b0); tick();
    drv(1'b1, 1'b1, 1'b0, 16'h104, 3'd0, 1'b1); tick();
    idle(1);
    check_val("unstable_flags", 32'(err_flags), 32'h08);
    clear_pulse();

    // timeout fires once, TMO cycles after the strobe
    drv(1'b1, 1'b1, 1'b0, 16'h200, 3'd0, 1'b0); repeat (TMO - 1) tick();
    check_val("tmo_early", 32'(err_flags), 0);
    tick();
    check_val("tmo_flags", 32'(err_flags), 32'h10);
    check_val("tmo_code", 32'(err_code), 4);
    repeat (4) tick();
    check_val("tmo_once", 32'(err_cnt), 1);
    drv(1'b1, 1'b1, 1'b0, 16'h200, 3'd0, 1'b1); tick();
    idle(1);
    clear_pulse();

    // bursts: clean, bad third address, cyc dropped after beat two
    burst_seq(16'h8, 1'b0);
    check_val("burst_txn", 32'(txn_cnt), 4);
    check_val("burst_cnt", 32'(burst_cnt), BEN ? 1 : 0);
    check_val("burst_flags", 32'(err_flags), 0);
    clear_pulse();
    burst_seq(16'h10, 1'b0);
    check_val("burst_addr_flags", 32'(err_flags), BEN ? 32'h20 : 32'h00);
    clear_pulse();
    burst_seq(16'h8, 1'b1);
    check_val("burst_abort_flags", 32'(err_flags), BEN ? 32'h40 : 32'h00);
    check_val("burst_abort_txn", 32'(txn_cnt), 2);

    // clear coinciding with a violation keeps the new flag and loads the counter with 1
    clr = 1'b1;
    drv(1'b0, 1'b0, 1'b0, '0, 3'd0, 1'b1); tick();
    clr = 1'b0;
    check_val("clr_viol_flags", 32'(err_flags), 32'h01);
    check_val("clr_viol_errc", 32'(err_cnt), 1);
    check_val("clr_viol_txn", 32'(txn_cnt), 0);
    idle(1);

    // counter saturation
    drv(1'b1, 1'b1, 1'b0, 16'h300, 3'd0, 1'b1); repeat (CMAX + 7) tick();
    idle(1);
    check_val("txn_saturate", 32'(txn_cnt), CMAX);

    // reset released with cyc high
    do_reset(1'b1);
    tick();
    check_val("rst_cyc_flags", 32'(err_flags), 32'h80);
    check_val("rst_cyc_code", 32'(err_code), 7);
    idle(1);

    // reset mid-access and mid-burst
    drv(1'b1, 1'b1, 1'b0, 16'h40, 3'd0, 1'b0); tick(); tick();
    do_reset(1'b0);
    idle(1);
    check_val("rst_mid_flags", 32'(err_flags), 0);
    drv(1'b1, 1'b1, 1'b1, 16'h0, 3'b010, 1'b1); tick();
    drv(1'b1, 1'b1, 1'b1, 16'h4, 3'b010, 1'b0); tick();
    do_reset(1'b0);
    idle(2);
    check_val("rst_burst_flags", 32'(err_flags), 0);

    // random traffic
    p_wait = 1'b0;
    p_inc  = 1'b0;
    for (int i = 0; i < 2400; i++) begin
      slow = ((i / 200) % 2 == 1) ? 1 : 0;
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1'b0);
        p_wait = 1'b0;
        p_inc  = 1'b0;
      end
      clr = ($urandom_range(0, 59) == 0);
      if (!p_wait) begin
        if (p_inc && $urandom_range(0, 9) != 0) addr = addr + 16'd4;
        else addr = 16'($urandom) & 16'hFFFC;
        we  = 1'($urandom);
        dat = $urandom;
        sel = 4'($urandom);
        cti = cti_tab[$urandom_range(0, 7)];
      end else if ($urandom_range(0, 39) == 0) begin
        addr = addr ^ 16'h4;
      end
      cyc = ($urandom_range(0, 99) < 94);
      stb = cyc ? ($urandom_range(0, 99) < (slow != 0 ? 97 : 75)) : ($urandom_range(0, 40) == 0);
      ack = stb ? ($urandom_range(0, 99) < (slow != 0 ? 6 : 40)) : ($urandom_range(0, 60) == 0);
      tick();
      p_wait = cyc && stb && !ack;
      p_inc  = cyc && stb && ack && (cti == 3'b010);
    end
    clr = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
